// File: rtl/phy_link_manager.sv
// SGMII PHY reset sequencer and link supervisor: holds the PHY in reset, waits
// for it to settle, kicks autonegotiation and debounces the PCS link status.
module phy_link_manager #(
  parameter int unsigned RESET_CYCLES        = 1250000,
  parameter int unsigned SETTLE_CYCLES       = 625000,
  parameter int unsigned LINK_TIMEOUT_CYCLES = 125000000,
  parameter int unsigned LINK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] status_vector,
  input  logic        restart,
  output logic        phy_reset_n,
  output logic        an_restart,
  output logic        link_up,
  output logic [1:0]  state,
  output logic [15:0] link_drop_count,
  output logic [7:0]  retry_count
);

  localparam int unsigned MAX_RS  = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_TS  = (LINK_TIMEOUT_CYCLES > LINK_STABLE_CYCLES) ?
                                    LINK_TIMEOUT_CYCLES : LINK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_RS > MAX_TS) ? MAX_RS : MAX_TS;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned SW      = (LINK_STABLE_CYCLES > 1) ? $clog2(LINK_STABLE_CYCLES) : 1;
  localparam int unsigned CW      = $clog2(MAX_RETRIES + 1);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_WAIT_LINK = 2'd2,
    ST_UP        = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   stable_q, stable_d;
  logic [CW-1:0]   consec_q, consec_d;
  logic            an_restart_q, an_restart_d;
  logic            link_up_q;
  logic            phy_rst_n_q;
  logic [1:0]      sync1_q, sync2_q;
  logic [15:0]     drop_cnt_q;
  logic [7:0]      retry_cnt_q;
  logic            link_ok;
  logic            drop_evt;
  logic            retry_evt;
  logic            unused_status;

  assign unused_status = ^status_vector[15:2];
  assign link_ok       = sync2_q[0] & sync2_q[1];

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TW'(1);
    stable_d     = stable_q;
    consec_d     = consec_q;
    an_restart_d = 1'b0;
    drop_evt     = 1'b0;
    retry_evt    = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (timer_q == TW'(RESET_CYCLES - 1)) begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end
      end
      ST_SETTLE: begin
        if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
          state_d      = ST_WAIT_LINK;
          timer_d      = '0;
          stable_d     = '0;
          consec_d     = '0;
          an_restart_d = 1'b1;
        end
      end
      ST_WAIT_LINK: begin
        stable_d = link_ok ? stable_q + SW'(1) : '0;
        // A stable link on the timeout cycle still counts as link up.
        if (link_ok && (stable_q == SW'(LINK_STABLE_CYCLES - 1))) begin
          state_d  = ST_UP;
          timer_d  = '0;
          stable_d = '0;
        end else if (timer_q == TW'(LINK_TIMEOUT_CYCLES - 1)) begin
          retry_evt = 1'b1;
          timer_d   = '0;
          stable_d  = '0;
          if (consec_q == CW'(MAX_RETRIES - 1)) begin
            state_d  = ST_RESET;
            consec_d = '0;
          end else begin
            consec_d     = consec_q + CW'(1);
            an_restart_d = 1'b1;
          end
        end
      end
      ST_UP: begin
        timer_d = '0;
        if (!link_ok) begin
          drop_evt     = 1'b1;
          state_d      = ST_WAIT_LINK;
          stable_d     = '0;
          consec_d     = '0;
          an_restart_d = 1'b1;
        end
      end
      default: state_d = ST_RESET;
    endcase
    // Restart overrides the transition only; events seen this cycle are still counted.
    if (restart) begin
      state_d      = ST_RESET;
      timer_d      = '0;
      an_restart_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      timer_q      <= '0;
      stable_q     <= '0;
      consec_q     <= '0;
      an_restart_q <= 1'b0;
      link_up_q    <= 1'b0;
      phy_rst_n_q  <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      drop_cnt_q   <= '0;
      retry_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      stable_q     <= stable_d;
      consec_q     <= consec_d;
      an_restart_q <= an_restart_d;
      link_up_q    <= (state_d == ST_UP);
      phy_rst_n_q  <= (state_d != ST_RESET);
      sync1_q      <= status_vector[1:0];
      sync2_q      <= sync1_q;
      if (drop_evt && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      if (retry_evt && (retry_cnt_q != '1)) begin
        retry_cnt_q <= retry_cnt_q + 8'd1;
      end
    end
  end

  assign state           = state_q;
  assign phy_reset_n     = phy_rst_n_q;
  assign an_restart      = an_restart_q;
  assign link_up         = link_up_q;
  assign link_drop_count = drop_cnt_q;
  assign retry_count     = retry_cnt_q;

endmodule

// File: tb/tb_phy_link_manager.sv
// Scoreboard bench for phy_link_manager: a phase/elapsed-time reference model
// predicts every cycle's outputs; a monitor compares them after each edge.
module tb_phy_link_manager;

  localparam int unsigned P_RESET   = 8;
  localparam int unsigned P_SETTLE  = 4;
  localparam int unsigned P_STABLE  = 3;
  localparam int unsigned P_TIMEOUT = 20;
  localparam int unsigned P_RETRIES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] status_vector = '0;
  logic        restart = 1'b0;
  logic        phy_reset_n;
  logic        an_restart;
  logic        link_up;
  logic [1:0]  state;
  logic [15:0] link_drop_count;
  logic [7:0]  retry_count;

  phy_link_manager #(
    .RESET_CYCLES       (P_RESET),
    .SETTLE_CYCLES      (P_SETTLE),
    .LINK_TIMEOUT_CYCLES(P_TIMEOUT),
    .LINK_STABLE_CYCLES (P_STABLE),
    .MAX_RETRIES        (P_RETRIES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .status_vector  (status_vector),
    .restart        (restart),
    .phy_reset_n    (phy_reset_n),
    .an_restart     (an_restart),
    .link_up        (link_up),
    .state          (state),
    .link_drop_count(link_drop_count),
    .retry_count    (retry_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int unsigned st;
    int unsigned prst;
    int unsigned anr;
    int unsigned lup;
    int unsigned drops;
    int unsigned retries;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: phase 0=reset,1=settle,2=wait link,3=up
  int   m_phase, m_elapsed, m_run, m_consec, m_drops, m_retries, m_pulse;
  bit   hist[$];

  function automatic void chk(string name, int unsigned got, int unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, want);
    end
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_elapsed = 0; m_run = 0; m_consec = 0;
    m_drops = 0; m_retries = 0; m_pulse = 0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    exp_q.delete();
  endfunction

  // Advance the model over one rising edge with the given inputs.
  function automatic void model_step(logic [15:0] sv, logic rs);
    bit   lk;
    int   nxt;
    exp_t e;
    lk = hist.pop_front();
    hist.push_back(sv[0] & sv[1]);
    nxt = m_phase;
    m_pulse = 0;
    case (m_phase)
      0: begin
        m_elapsed++;
        if (m_elapsed == int'(P_RESET)) begin nxt = 1; m_elapsed = 0; end
      end
      1: begin
        m_elapsed++;
        if (m_elapsed == int'(P_SETTLE)) begin
          nxt = 2; m_elapsed = 0; m_run = 0; m_consec = 0; m_pulse = 1;
        end
      end
      2: begin
        m_elapsed++;
        m_run = lk ? m_run + 1 : 0;
        if (m_run == int'(P_STABLE)) begin
          nxt = 3; m_run = 0; m_elapsed = 0;
        end else if (m_elapsed == int'(P_TIMEOUT)) begin
          if (m_retries < 255) m_retries++;
          m_consec++;
          m_elapsed = 0; m_run = 0;
          if (m_consec == int'(P_RETRIES)) begin nxt = 0; m_consec = 0; end
          else m_pulse = 1;
        end
      end
      default: begin
        if (!lk) begin
          if (m_drops < 65535) m_drops++;
          nxt = 2; m_run = 0; m_elapsed = 0; m_consec = 0; m_pulse = 1;
        end
      end
    endcase
    if (rs) begin
      nxt = 0; m_elapsed = 0; m_pulse = 0;
    end
    m_phase   = nxt;
    e.st      = m_phase;
    e.prst    = (m_phase != 0) ? 1 : 0;
    e.anr     = m_pulse;
    e.lup     = (m_phase == 3) ? 1 : 0;
    e.drops   = m_drops;
    e.retries = m_retries;
    exp_q.push_back(e);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        chk("state", state, e.st);
        chk("phy_reset_n", phy_reset_n, e.prst);
        chk("an_restart", an_restart, e.anr);
        chk("link_up", link_up, e.lup);
        chk("link_drop_count", link_drop_count, e.drops);
        chk("retry_count", retry_count, e.retries);
      end
    end
  end

  function automatic logic [15:0] rand_sv(bit ok);
    logic [15:0] v;
    v = 16'($urandom);
    v[1:0] = ok ? 2'b11 : 2'($urandom_range(0, 2));
    return v;
  endfunction

  // Called at a falling edge: drive inputs for the next rising edge.
  task automatic cycle(input logic [15:0] sv, input logic rs);
    status_vector = sv;
    restart       = rs;
    model_step(sv, rs);
    @(negedge clk);
  endtask

  task automatic hold(input int n, input bit ok);
    for (int i = 0; i < n; i++) cycle(rand_sv(ok), 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_phy_reset_n"}, phy_reset_n, 0);
    chk({tag, "_an_restart"}, an_restart, 0);
    chk({tag, "_link_up"}, link_up, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_drops"}, link_drop_count, 0);
    chk({tag, "_retries"}, retry_count, 0);
  endtask

  task automatic apply_reset(input string tag);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    restart = 1'b0;
    status_vector = '0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;
    int len;
    rst_n = 1'b0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // nominal bring-up, then a single-cycle drop
    hold(14, 1'b0);
    hold(8, 1'b1);
    hold(1, 1'b0);
    hold(8, 1'b1);

    // restart during UP, then a glitchy link in WAIT_LINK
    cycle(rand_sv(1'b1), 1'b1);
    hold(12, 1'b0);
    hold(2, 1'b1);
    hold(1, 1'b0);
    hold(8, 1'b1);

    // restart on the same edge the drop is seen
    cycle(rand_sv(1'b0), 1'b0);
    cycle(rand_sv(1'b1), 1'b0);
    cycle(rand_sv(1'b1), 1'b1);
    hold(20, 1'b1);

    // timeout escalation back to RESET
    cycle(rand_sv(1'b1), 1'b1);
    hold(70, 1'b0);

    // asynchronous reset while settling
    cycle(rand_sv(1'b0), 1'b1);
    hold(10, 1'b0);
    chk("pre_async_state", state, 1);
    apply_reset("async");

    // retry counter saturation
    hold(7000, 1'b0);
    chk("retry_saturated", retry_count, 255);

    // drop counter saturation from a preloaded value
    cycle(rand_sv(1'b0), 1'b1);
    hold(14, 1'b0);
    hold(8, 1'b1);
    force dut.drop_cnt_q = 16'hFFFE;
    #1;
    release dut.drop_cnt_q;
    m_drops = 65534;
    hold(1, 1'b0);
    hold(8, 1'b1);
    hold(1, 1'b0);
    hold(8, 1'b1);
    chk("drop_saturated", link_drop_count, 65535);

    // randomized link noise with occasional restarts
    n = 0;
    while (n < 3000) begin
      ok  = ($urandom_range(0, 9) < 6);
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        cycle(rand_sv(ok), ($urandom_range(0, 199) == 0));
        n++;
      end
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
